// File: rtl/hsk_cobs_rx_decoder.sv
// ---------------------------------------------------------------------------
// hsk_cobs_rx_decoder
//
// Housekeeping-path COBS frame decoder. Pops encoded bytes from the uart_rx6
// receive FIFO, removes COBS byte stuffing, splits frames on 0x00 delimiters
// and presents the decoded bytes as a valid/ready stream. The last byte of a
// frame carries m_tlast_o; m_tuser_o marks a frame that ended badly
// (premature delimiter or longer than MAX_LEN decoded bytes).
//
// Parameters
//   MAX_LEN  maximum decoded bytes per frame; longer frames are truncated
//   CNT_W    width of the frame statistics counters
//
// Ports
//   wb_clk_i      system clock
//   wb_rst_i      synchronous reset, active-high
//   rx_data_i     FIFO head byte
//   rx_present_i  FIFO holds at least one byte
//   rx_read_o     one-cycle pop strobe; rx_data_i is consumed in that cycle
//   m_tdata_o     decoded byte
//   m_tvalid_o    decoded byte valid
//   m_tready_i    downstream ready
//   m_tlast_o     last byte of frame
//   m_tuser_o     frame error tag (meaningful with m_tlast_o)
//   err_o         one-cycle pulse per bad frame
//   frames_ok_o   good-frame count (statistics build only, else 0)
//   frames_err_o  bad-frame count  (statistics build only, else 0)
//
// Build option
//   HSK_COBS_STATS_EN  when defined, frames_ok_o / frames_err_o are
//                      saturating counters; otherwise they are tied to 0.
// ---------------------------------------------------------------------------
module hsk_cobs_rx_decoder #(
    parameter int MAX_LEN = 256,
    parameter int CNT_W   = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic [7:0]       rx_data_i,
    input  logic             rx_present_i,
    output logic             rx_read_o,
    output logic [7:0]       m_tdata_o,
    output logic             m_tvalid_o,
    input  logic             m_tready_i,
    output logic             m_tlast_o,
    output logic             m_tuser_o,
    output logic             err_o,
    output logic [CNT_W-1:0] frames_ok_o,
    output logic [CNT_W-1:0] frames_err_o
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);

    typedef enum logic [1:0] {
        ST_CODE    = 2'd0,
        ST_DATA    = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    state_t             r_state;
    logic [7:0]         r_rem;
    logic               r_pend;
    logic [LEN_W-1:0]   r_len;
    logic               r_h_vld;
    logic [7:0]         r_h_data;
    logic [7:0]         r_o_data;
    logic               r_o_vld;
    logic               r_o_last;
    logic               r_o_user;
    logic               r_err;
    logic               r_rd_prev;

    logic               w_rd;
    logic               w_push_req;
    logic [7:0]         w_push_data;
    logic               w_eof;
    logic               w_bad;
    logic               w_ovf;
    logic               w_push;
    logic               w_end;
    state_t             w_state_nxt;
    logic [7:0]         w_rem_nxt;
    logic               w_pend_nxt;

    // Pop only when the output register can absorb a byte moved out of the
    // hold register this cycle; never pop on two consecutive cycles so the
    // FIFO head has time to advance.
    assign w_rd = rx_present_i & ~r_rd_prev & (~r_o_vld | m_tready_i) & ~wb_rst_i;
    assign rx_read_o = w_rd;

    always_comb begin
        w_push_req  = 1'b0;
        w_push_data = rx_data_i;
        w_eof       = 1'b0;
        w_bad       = 1'b0;
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_pend_nxt  = r_pend;
        if (w_rd) begin
            unique case (r_state)
                ST_CODE: begin
                    if (rx_data_i == 8'h00) begin
                        // Normal end of frame: the zero implied by the last
                        // code block is dropped.
                        w_eof      = 1'b1;
                        w_pend_nxt = 1'b0;
                    end else begin
                        if (r_pend) begin
                            w_push_req  = 1'b1;
                            w_push_data = 8'h00;
                        end
                        w_rem_nxt   = rx_data_i - 8'd1;
                        w_pend_nxt  = (rx_data_i != 8'hFF);
                        w_state_nxt = (rx_data_i != 8'h01) ? ST_DATA : ST_CODE;
                    end
                end
                ST_DATA: begin
                    if (rx_data_i == 8'h00) begin
                        w_bad       = 1'b1;
                        w_pend_nxt  = 1'b0;
                        w_state_nxt = ST_CODE;
                    end else begin
                        w_push_req = 1'b1;
                        w_rem_nxt  = r_rem - 8'd1;
                        if (r_rem == 8'd1) begin
                            w_state_nxt = ST_CODE;
                        end
                    end
                end
                ST_DISCARD: begin
                    if (rx_data_i == 8'h00) begin
                        w_pend_nxt  = 1'b0;
                        w_state_nxt = ST_CODE;
                    end
                end
                default: begin
                    w_state_nxt = ST_CODE;
                end
            endcase
        end
        // A push beyond MAX_LEN is dropped and the rest of the frame skipped.
        w_ovf = w_push_req && (r_len >= LEN_W'(MAX_LEN));
        if (w_ovf) begin
            w_state_nxt = ST_DISCARD;
            w_pend_nxt  = 1'b0;
        end
        w_push = w_push_req & ~w_ovf;
        w_end  = w_eof | w_bad | w_ovf;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state   <= ST_CODE;
            r_rem     <= 8'd0;
            r_pend    <= 1'b0;
            r_len     <= '0;
            r_h_vld   <= 1'b0;
            r_o_data  <= 8'h00;
            r_o_vld   <= 1'b0;
            r_o_last  <= 1'b0;
            r_o_user  <= 1'b0;
            r_err     <= 1'b0;
            r_rd_prev <= 1'b0;
        end else begin
            r_rd_prev <= w_rd;
            r_err     <= w_bad | w_ovf;
            r_state   <= w_state_nxt;
            r_rem     <= w_rem_nxt;
            r_pend    <= w_pend_nxt;

            if (r_o_vld && m_tready_i) begin
                r_o_vld <= 1'b0;
            end

            // The hold register keeps the newest byte back so that the
            // delimiter can still tag it as the last one of the frame.
            if (w_push) begin
                if (r_h_vld) begin
                    r_o_data <= r_h_data;
                    r_o_vld  <= 1'b1;
                    r_o_last <= 1'b0;
                    r_o_user <= 1'b0;
                end
                r_h_data <= w_push_data;
                r_h_vld  <= 1'b1;
                r_len    <= r_len + LEN_W'(1);
            end

            if (w_end) begin
                if (r_h_vld) begin
                    r_o_data <= r_h_data;
                    r_o_vld  <= 1'b1;
                    r_o_last <= 1'b1;
                    r_o_user <= w_bad | w_ovf;
                end
                r_h_vld <= 1'b0;
                r_len   <= '0;
            end
        end
    end

    assign m_tdata_o  = r_o_data;
    assign m_tvalid_o = r_o_vld;
    assign m_tlast_o  = r_o_last;
    assign m_tuser_o  = r_o_user;
    assign err_o      = r_err;

`ifdef HSK_COBS_STATS_EN
    logic [CNT_W-1:0] r_ok_cnt;
    logic [CNT_W-1:0] r_err_cnt;

    // Counted when the frame's last byte enters the output register.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ok_cnt  <= '0;
            r_err_cnt <= '0;
        end else begin
            if (w_eof && r_h_vld && (r_ok_cnt != '1)) begin
                r_ok_cnt <= r_ok_cnt + CNT_W'(1);
            end
            if ((w_bad || w_ovf) && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + CNT_W'(1);
            end
        end
    end

    assign frames_ok_o  = r_ok_cnt;
    assign frames_err_o = r_err_cnt;
`else
    assign frames_ok_o  = '0;
    assign frames_err_o = '0;
`endif

endmodule

// File: tb/tb_hsk_cobs_rx_decoder.sv
module tb_hsk_cobs_rx_decoder;

    localparam int MAXL0 = 256;
    localparam int MAXL1 = 8;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data0, rx_data1;
    logic        rx_present0, rx_present1;
    logic        rx_read0, rx_read1;
    logic [7:0]  tdata0, tdata1;
    logic        tvalid0, tvalid1;
    logic        rdy0, rdy1;
    logic        tlast0, tlast1;
    logic        tuser0, tuser1;
    logic        err0, err1;
    logic [15:0] fok0, fok1, ferr0, ferr1;

    hsk_cobs_rx_decoder #(.MAX_LEN(MAXL0), .CNT_W(16)) u_dut0 (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .rx_data_i(rx_data0), .rx_present_i(rx_present0), .rx_read_o(rx_read0),
        .m_tdata_o(tdata0), .m_tvalid_o(tvalid0), .m_tready_i(rdy0),
        .m_tlast_o(tlast0), .m_tuser_o(tuser0), .err_o(err0),
        .frames_ok_o(fok0), .frames_err_o(ferr0)
    );

    hsk_cobs_rx_decoder #(.MAX_LEN(MAXL1), .CNT_W(16)) u_dut1 (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .rx_data_i(rx_data1), .rx_present_i(rx_present1), .rx_read_o(rx_read1),
        .m_tdata_o(tdata1), .m_tvalid_o(tvalid1), .m_tready_i(rdy1),
        .m_tlast_o(tlast1), .m_tuser_o(tuser1), .err_o(err1),
        .frames_ok_o(fok1), .frames_err_o(ferr1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // FIFO models, captured outputs, and error pulse counts
    logic [7:0] fifo0[$];
    logic [7:0] fifo1[$];
    logic [9:0] got0[$];
    logic [9:0] got1[$];
    int         errs0, errs1;
    int         stall_cycles;
    logic       pop0, pop1, hs0, hs1;
    logic [9:0] cap0, cap1, prev_cap0, prev_cap1;
    logic       prev_stall0, prev_stall1;

    // Stimulus, reference model results, running frame totals
    logic [7:0] stim[$];
    logic [9:0] mq[$];
    int         m_ok, m_err;
    int         tot_ok0, tot_err0, tot_ok1, tot_err1;

    // Bench-side FIFO/sink: inputs change on the falling edge, and the
    // pop/handshake decisions for the next rising edge are sampled 1 time unit later.
    initial begin
        pop0 = 1'b0; pop1 = 1'b0; hs0 = 1'b0; hs1 = 1'b0;
        cap0 = '0; cap1 = '0; prev_cap0 = '0; prev_cap1 = '0;
        prev_stall0 = 1'b0; prev_stall1 = 1'b0;
        rdy0 = 1'b0; rdy1 = 1'b0;
        rx_present0 = 1'b0; rx_present1 = 1'b0;
        rx_data0 = 8'h00; rx_data1 = 8'h00;
        forever begin
            @(negedge clk);
            if (pop0 && fifo0.size() > 0) void'(fifo0.pop_front());
            if (pop1 && fifo1.size() > 0) void'(fifo1.pop_front());
            if (hs0) got0.push_back(cap0);
            if (hs1) got1.push_back(cap1);
            if (stall_cycles > 0) begin
                rdy0 = 1'b0; rdy1 = 1'b0;
                stall_cycles--;
            end else begin
                rdy0 = ($urandom % 4) != 0;
                rdy1 = ($urandom % 4) != 0;
            end
            rx_present0 = fifo0.size() > 0;
            rx_data0    = (fifo0.size() > 0) ? fifo0[0] : 8'h00;
            rx_present1 = fifo1.size() > 0;
            rx_data1    = (fifo1.size() > 0) ? fifo1[0] : 8'h00;
            #1;
            pop0 = rx_read0;
            pop1 = rx_read1;
            cap0 = {tuser0, tlast0, tdata0};
            cap1 = {tuser1, tlast1, tdata1};
            hs0  = tvalid0 & rdy0;
            hs1  = tvalid1 & rdy1;
            if (prev_stall0 && tvalid0) chk("stall_stable0", {22'd0, cap0}, {22'd0, prev_cap0});
            if (prev_stall1 && tvalid1) chk("stall_stable1", {22'd0, cap1}, {22'd0, prev_cap1});
            prev_stall0 = tvalid0 & ~rdy0;
            prev_stall1 = tvalid1 & ~rdy1;
            prev_cap0   = cap0;
            prev_cap1   = cap1;
            if (err0) errs0++;
            if (err1) errs1++;
        end
    end

    // Reference decoder: split on delimiters, expand each code block,
    // then apply the length limit. Produces {tuser,tlast,tdata} entries.
    task automatic model_run(input int maxlen);
        logic [7:0] fr[$];
        logic [7:0] out[$];
        int i, c, n;
        bit bad;
        mq = {}; m_ok = 0; m_err = 0; fr = {};
        foreach (stim[k]) begin
            if (stim[k] != 8'h00) begin
                fr.push_back(stim[k]);
            end else begin
                out = {}; bad = 1'b0; i = 0;
                while (i < fr.size()) begin
                    c = int'(fr[i]);
                    i++;
                    if (fr.size() - i < c - 1) begin
                        bad = 1'b1;
                        while (i < fr.size()) begin
                            out.push_back(fr[i]);
                            i++;
                        end
                    end else begin
                        for (int j = 0; j < c - 1; j++) begin
                            out.push_back(fr[i]);
                            i++;
                        end
                        if (c != 255 && i < fr.size()) out.push_back(8'h00);
                    end
                end
                if (out.size() > maxlen) begin
                    bad = 1'b1;
                    while (out.size() > maxlen) void'(out.pop_back());
                end
                n = out.size();
                for (int k2 = 0; k2 < n; k2++) begin
                    mq.push_back({bad && (k2 == n - 1), (k2 == n - 1), out[k2]});
                end
                if (bad) m_err++;
                else if (n > 0) m_ok++;
                fr = {};
            end
        end
    endtask

    // COBS encoder used to build well-formed random frames
    task automatic encode_frame(input logic [7:0] pl[$]);
        int ci, code;
        ci = stim.size();
        stim.push_back(8'h00);
        code = 1;
        foreach (pl[k]) begin
            if (pl[k] == 8'h00) begin
                stim[ci] = 8'(code);
                ci = stim.size();
                stim.push_back(8'h00);
                code = 1;
            end else begin
                stim.push_back(pl[k]);
                code++;
                if (code == 255) begin
                    stim[ci] = 8'hFF;
                    ci = stim.size();
                    stim.push_back(8'h00);
                    code = 1;
                end
            end
        end
        stim[ci] = 8'(code);
        stim.push_back(8'h00);
    endtask

    task automatic cmp_queue(input string tag, input int which);
        int n;
        if (which == 0) begin
            chk({tag, "_len0"}, got0.size(), mq.size());
            n = (got0.size() < mq.size()) ? got0.size() : mq.size();
            for (int k = 0; k < n; k++) chk($sformatf("%s_d0[%0d]", tag, k), {22'd0, got0[k]}, {22'd0, mq[k]});
            chk({tag, "_err0"}, errs0, m_err);
        end else begin
            chk({tag, "_len1"}, got1.size(), mq.size());
            n = (got1.size() < mq.size()) ? got1.size() : mq.size();
            for (int k = 0; k < n; k++) chk($sformatf("%s_d1[%0d]", tag, k), {22'd0, got1[k]}, {22'd0, mq[k]});
            chk({tag, "_err1"}, errs1, m_err);
        end
    endtask

    task automatic wait_idle(input string tag);
        int idle, cyc;
        logic timed_out;
        idle = 0;
        timed_out = 1'b1;
        for (cyc = 0; cyc < 8000; cyc++) begin
            @(negedge clk);
            #2;
            if (fifo0.size() == 0 && fifo1.size() == 0 && !tvalid0 && !tvalid1 && stall_cycles == 0)
                idle++;
            else
                idle = 0;
            if (idle > 4) begin
                timed_out = 1'b0;
                break;
            end
        end
        chk({tag, "_timeout"}, {31'd0, timed_out}, 32'd0);
    endtask

    task automatic run_phase(input string tag, input int stall);
        got0 = {}; got1 = {};
        errs0 = 0; errs1 = 0;
        @(negedge clk);
        #2;
        stall_cycles = stall;
        foreach (stim[k]) begin
            fifo0.push_back(stim[k]);
            fifo1.push_back(stim[k]);
        end
        wait_idle(tag);
        model_run(MAXL0);
        cmp_queue(tag, 0);
        tot_ok0 += m_ok; tot_err0 += m_err;
        model_run(MAXL1);
        cmp_queue(tag, 1);
        tot_ok1 += m_ok; tot_err1 += m_err;
    endtask

    task automatic chk_counters(input string tag);
`ifdef HSK_COBS_STATS_EN
        chk({tag, "_ok0"}, {16'd0, fok0}, tot_ok0);
        chk({tag, "_bad0"}, {16'd0, ferr0}, tot_err0);
        chk({tag, "_ok1"}, {16'd0, fok1}, tot_ok1);
        chk({tag, "_bad1"}, {16'd0, ferr1}, tot_err1);
`else
        chk({tag, "_ok0"}, {16'd0, fok0}, 0);
        chk({tag, "_bad0"}, {16'd0, ferr0}, 0);
        chk({tag, "_ok1"}, {16'd0, fok1}, 0);
        chk({tag, "_bad1"}, {16'd0, ferr1}, 0);
`endif
    endtask

    initial begin
        logic [7:0] pl[$];
        int plen;
        stall_cycles = 0;
        tot_ok0 = 0; tot_err0 = 0; tot_ok1 = 0; tot_err1 = 0;
        errs0 = 0; errs1 = 0;
        rst = 1'b1;
        // A byte waits in the FIFO during reset; it must not be popped.
        fifo0.push_back(8'h00);
        fifo1.push_back(8'h00);
        repeat (3) @(negedge clk);
        #2;
        chk("rst_read0", {31'd0, rx_read0}, 0);
        chk("rst_read1", {31'd0, rx_read1}, 0);
        chk("rst_valid0", {31'd0, tvalid0}, 0);
        chk("rst_last0", {31'd0, tlast0}, 0);
        chk("rst_user0", {31'd0, tuser0}, 0);
        chk("rst_err0", {31'd0, err0}, 0);
        chk("rst_data0", {24'd0, tdata0}, 0);
        chk("rst_valid1", {31'd0, tvalid1}, 0);
        chk("rst_fifo0_kept", fifo0.size(), 1);
        chk_counters("rst_cnt");
        @(negedge clk);
        rst = 1'b0;

        stim = {8'h01, 8'h02, 8'h40, 8'h01, 8'h01, 8'h01, 8'h00};
        run_phase("pingpong", 0);
        chk("pingpong_last", {22'd0, got0[got0.size()-1]}, 32'h100);

        stim = {8'h01, 8'h03, 8'h11, 8'h22, 8'h00};
        run_phase("stall", 20);

        stim = {8'h04, 8'hAA, 8'hBB, 8'h00};
        run_phase("premature", 0);
        chk("premature_tag", {22'd0, got0[got0.size()-1]}, 32'h3BB);

        stim = {8'hFF};
        for (int k = 0; k < 254; k++) stim.push_back(8'h5A);
        stim.push_back(8'h00);
        run_phase("ff_block", 0);

        stim = {8'h0A};
        for (int k = 0; k < 9; k++) stim.push_back(8'(8'h11 + k));
        stim.push_back(8'h00);
        run_phase("overflow", 0);

        stim = {8'h00, 8'h00, 8'h01, 8'h00};
        run_phase("empty", 0);

        stim = {8'h02, 8'h7E, 8'h00};
        run_phase("single", 0);

        stim = {};
        for (int f = 0; f < 14; f++) begin
            if (($urandom % 3) != 0) begin
                pl = {};
                plen = $urandom_range(0, 14);
                for (int k = 0; k < plen; k++)
                    pl.push_back((($urandom % 4) == 0) ? 8'h00 : 8'($urandom_range(1, 255)));
                encode_frame(pl);
            end else begin
                plen = $urandom_range(0, 6);
                for (int k = 0; k < plen; k++) stim.push_back(8'($urandom_range(1, 255)));
                stim.push_back(8'h00);
            end
        end
        run_phase("random", 0);

        chk_counters("cnt");

        // Reset in the middle of a frame: nothing emerges, next frame clean.
        got0 = {}; got1 = {};
        @(negedge clk);
        #2;
        fifo0.push_back(8'h03); fifo0.push_back(8'h11);
        fifo1.push_back(8'h03); fifo1.push_back(8'h11);
        wait_idle("midrst");
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #2;
        chk("midrst_out0", got0.size(), 0);
        chk("midrst_out1", got1.size(), 0);
        tot_ok0 = 0; tot_err0 = 0; tot_ok1 = 0; tot_err1 = 0;
        stim = {8'h02, 8'h7E, 8'h00};
        run_phase("after_rst", 0);
        chk("after_rst_byte", {22'd0, got0[0]}, 32'h17E);
        chk_counters("after_rst_cnt");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
